// File: rtl/loader_pkg.sv
// Shared types and constants for the UART-to-instruction-memory loader.
package loader_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      WRITE   = 2'd1,
      DONE    = 2'd2
   } loader_state_t;

   localparam int BYTES_PER_WORD     = 4;
   localparam int LANE_W             = $clog2(BYTES_PER_WORD);
   localparam int DEF_TIMEOUT_CYCLES = 500_000;

   function automatic logic [31:0] insert_byte(
      input logic [31:0]       w,
      input logic [LANE_W-1:0] lane,
      input logic [7:0]        b
   );
      logic [31:0] r;
      r = w;
      r[{lane, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte lane collector with clear and load controls.
module byte_packer
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic [7:0]        byte_i,
   output logic [LANE_W-1:0] lane_o,
   output logic [31:0]       word_o
);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [31:0]       word_q, word_d;

   // clr and load together start a fresh word with this byte in lane 0
   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (clr_i) begin
         lane_d = '0;
         word_d = '0;
      end
      if (load_i) begin
         word_d = insert_byte(word_d, lane_d, byte_i);
         lane_d = lane_d + LANE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         lane_q <= '0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

   assign lane_o = lane_q;
   assign word_o = word_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Packs UART bytes into 32-bit words and writes them to instruction memory.
module imem_uart_loader
   import loader_pkg::*;
#(
   parameter int NUM_WORDS      = 64,
   parameter int ADDR_W         = 6,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   words_loaded,
   output logic              load_done,
   output logic              frame_err
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W + 1)'(NUM_WORDS - 1);
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

   loader_state_t     state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              ferr_q, ferr_d;
   logic              pk_clr, pk_load;
   logic [LANE_W-1:0] lane;
   logic [31:0]       word;

   byte_packer u_packer (
      .clk    (clk),
      .rst_i  (rst_n),
      .clr_i  (pk_clr),
      .load_i (pk_load),
      .byte_i (rx_data),
      .lane_o (lane),
      .word_o (word)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      to_d    = '0;
      ferr_d  = ferr_q;
      pk_clr  = 1'b0;
      pk_load = 1'b0;
      unique case (state_q)
         COLLECT: begin
            pk_load = rx_valid;
            if (rx_valid) begin
               if (lane == LANE_LAST) begin
                  state_d = WRITE;
                  addr_d  = cnt_q[ADDR_W-1:0];
                  wdata_d = insert_byte(word, lane, rx_data);
               end
            end else if (lane != '0) begin
               // stalled mid-word: drop the partial word
               if (to_q == TO_LAST) begin
                  pk_clr = 1'b1;
                  ferr_d = 1'b1;
               end else begin
                  to_d = to_q + TO_W'(1);
               end
            end
         end
         WRITE: begin
            cnt_d  = cnt_q + (ADDR_W + 1)'(1);
            pk_clr = 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               state_d = COLLECT;
               pk_load = rx_valid;
            end
         end
         DONE: begin
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         to_q    <= '0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         to_q    <= to_d;
         ferr_q  <= ferr_d;
      end
   end

   assign imem_we      = (state_q == WRITE);
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign words_loaded = cnt_q;
   assign load_done    = (state_q == DONE);
   assign frame_err    = ferr_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized self-checking bench for imem_uart_loader against a byte-stream model.
module tb_imem_uart_loader;

   localparam int NW = 64;
   localparam int AW = 6;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   words_loaded;
   logic          load_done;
   logic          frame_err;

   imem_uart_loader #(
      .NUM_WORDS      (NW),
      .ADDR_W         (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .words_loaded (words_loaded),
      .load_done    (load_done),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // observed writes, sampled mid-cycle
   int          got_addr[$];
   logic [31:0] got_data[$];
   int          got_cyc[$];
   int          done_cyc = -1;
   always @(negedge clk) begin
      if (rst_n) done_cyc = -1;
      else if (load_done && done_cyc < 0) done_cyc = cyc;
      if (imem_we) begin
         got_addr.push_back(int'(imem_addr));
         got_data.push_back(imem_wdata);
         got_cyc.push_back(cyc);
      end
   end

   // reference model: every 4 accepted bytes form one word
   logic [7:0]  mbuf[$];
   int          mcount;
   bit          mdone;
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_cyc[$];

   int errs = 0;
   int checks = 0;

   task automatic tick(input logic v, input logic [7:0] d);
      @(posedge clk);
      #1;
      rx_valid = v;
      rx_data  = d;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'h00);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) tick(1'b0, 8'h00);
      tick(1'b1, b);
      if (!mdone) begin
         mbuf.push_back(b);
         if (mbuf.size() == 4) begin
            exp_addr.push_back(mcount);
            exp_data.push_back({mbuf[3], mbuf[2], mbuf[1], mbuf[0]});
            exp_cyc.push_back(cyc + 1);
            mcount++;
            mbuf.delete();
            if (mcount == NW) mdone = 1'b1;
         end
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int k = 0; k < 4; k++)
         send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
   endtask

   task automatic do_reset;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      mbuf.delete();
      mcount = 0;
      mdone = 1'b0;
      got_addr.delete(); got_data.delete(); got_cyc.delete();
      exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({imem_we, imem_addr, imem_wdata} !== '0) begin
         errs++;
         $display("FAIL reset_wr: got we=%b addr=%0d data=%h want 0",
                  imem_we, imem_addr, imem_wdata);
      end
      checks++;
      if ({words_loaded, load_done, frame_err} !== '0) begin
         errs++;
         $display("FAIL reset_stat: got wl=%0d done=%b ferr=%b want 0",
                  words_loaded, load_done, frame_err);
      end
   endtask

   task automatic test_single;
      do_reset();
      send_byte(8'h93, $urandom_range(0, 3));
      send_byte(8'h02, $urandom_range(0, 3));
      send_byte(8'hA0, $urandom_range(0, 3));
      send_byte(8'h00, $urandom_range(0, 3));
      idle(4);
      checks++;
      if (got_addr.size() !== 1) begin
         errs++;
         $display("FAIL single_cnt: got %0d writes want 1", got_addr.size());
      end else begin
         checks++;
         if (got_addr[0] !== 0 || got_data[0] !== 32'h00A00293
             || got_cyc[0] !== exp_cyc[0]) begin
            errs++;
            $display("FAIL single_wr: got a=%0d d=%h c=%0d want a=0 d=00a00293 c=%0d",
                     got_addr[0], got_data[0], got_cyc[0], exp_cyc[0]);
         end
      end
      checks++;
      if (words_loaded !== 7'd1) begin
         errs++;
         $display("FAIL single_wl: got %0d want 1", words_loaded);
      end
   endtask

   task automatic test_back_to_back;
      do_reset();
      send_word($urandom, 2);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, $urandom_range(0, 2));
      send_byte(8'hCC, $urandom_range(0, 2));
      send_byte(8'hDD, $urandom_range(0, 2));
      idle(4);
      checks++;
      if (got_addr.size() !== 2) begin
         errs++;
         $display("FAIL b2b_cnt: got %0d writes want 2", got_addr.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]
                || got_cyc[i] !== exp_cyc[i]) begin
               errs++;
               $display("FAIL b2b_wr%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                        i, got_addr[i], got_data[i], got_cyc[i],
                        exp_addr[i], exp_data[i], exp_cyc[i]);
            end
         end
         checks++;
         if (got_addr[1] !== 1 || got_data[1] !== 32'hDDCCBBAA) begin
            errs++;
            $display("FAIL b2b_word1: got a=%0d d=%h want a=1 d=ddccbbaa",
                     got_addr[1], got_data[1]);
         end
      end
   endtask

   task automatic test_timeout;
      do_reset();
      send_byte(8'h13, 1);
      send_byte(8'h00, 1);
      idle(20);
      mbuf.delete();
      checks++;
      if (frame_err !== 1'b1 || got_addr.size() !== 0) begin
         errs++;
         $display("FAIL to_drop: got ferr=%b writes=%0d want ferr=1 writes=0",
                  frame_err, got_addr.size());
      end
      send_word(32'h00530333, 2);
      idle(4);
      checks++;
      if (got_addr.size() !== 1) begin
         errs++;
         $display("FAIL to_cnt: got %0d writes want 1", got_addr.size());
      end else begin
         checks++;
         if (got_addr[0] !== 0 || got_data[0] !== 32'h00530333) begin
            errs++;
            $display("FAIL to_wr: got a=%0d d=%h want a=0 d=00530333",
                     got_addr[0], got_data[0]);
         end
      end
      checks++;
      if (frame_err !== 1'b1) begin
         errs++;
         $display("FAIL to_sticky: got %b want 1", frame_err);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      for (int i = 0; i < 10; i++) send_word($urandom, 3);
      send_byte(8'($urandom), 1);
      send_byte(8'($urandom), 1);
      checks++;
      if (words_loaded !== 7'd10) begin
         errs++;
         $display("FAIL mid_wl: got %0d want 10", words_loaded);
      end
      do_reset();
      checks++;
      if ({imem_we, imem_addr, imem_wdata, words_loaded, load_done, frame_err} !== '0) begin
         errs++;
         $display("FAIL mid_reset: got we=%b a=%0d d=%h wl=%0d want all 0",
                  imem_we, imem_addr, imem_wdata, words_loaded);
      end
      send_word(32'hCAFEF00D, 2);
      idle(4);
      checks++;
      if (got_addr.size() !== 1 || got_addr[0] !== 0 || got_data[0] !== 32'hCAFEF00D) begin
         errs++;
         $display("FAIL mid_rewrite: got writes=%0d want 1 write to a=0 d=cafef00d",
                  got_addr.size());
      end
   endtask

   task automatic test_full_image;
      logic [31:0] prog [5];
      int n;
      prog = '{32'h00A00293, 32'h00528333, 32'h0A5032A3,
               32'h00503383, 32'hFE000EE3};
      do_reset();
      for (int i = 0; i < NW; i++)
         send_word(i < 5 ? prog[i] : 32'h00000013, 4);
      idle(3);
      checks++;
      if (got_addr.size() !== NW) begin
         errs++;
         $display("FAIL full_cnt: got %0d writes want %0d", got_addr.size(), NW);
      end
      n = got_addr.size() < exp_addr.size() ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got_addr[i] !== i || got_data[i] !== exp_data[i]
             || got_cyc[i] !== exp_cyc[i]) begin
            errs++;
            $display("FAIL full_wr%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                     i, got_addr[i], got_data[i], got_cyc[i],
                     i, exp_data[i], exp_cyc[i]);
         end
      end
      checks++;
      if (done_cyc !== exp_cyc[NW-1] + 1) begin
         errs++;
         $display("FAIL full_done: got rise at %0d want %0d",
                  done_cyc, exp_cyc[NW-1] + 1);
      end
      send_word(32'h12345678, 1);
      idle(3);
      checks++;
      if (got_addr.size() !== NW || words_loaded !== 7'd64 || load_done !== 1'b1) begin
         errs++;
         $display("FAIL full_after: got writes=%0d wl=%0d done=%b want %0d 64 1",
                  got_addr.size(), words_loaded, load_done, NW);
      end
   endtask

   task automatic test_random_stream;
      int n;
      do_reset();
      for (int i = 0; i < 4 * NW + 7; i++)
         send_byte(8'($urandom), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5));
      idle(4);
      checks++;
      if (got_addr.size() !== exp_addr.size()) begin
         errs++;
         $display("FAIL rnd_cnt: got %0d writes want %0d",
                  got_addr.size(), exp_addr.size());
      end
      n = got_addr.size() < exp_addr.size() ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]
             || got_cyc[i] !== exp_cyc[i]) begin
            errs++;
            $display("FAIL rnd_wr%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                     i, got_addr[i], got_data[i], got_cyc[i],
                     exp_addr[i], exp_data[i], exp_cyc[i]);
         end
      end
      checks++;
      if (words_loaded !== 7'(mcount) || load_done !== mdone || frame_err !== 1'b0) begin
         errs++;
         $display("FAIL rnd_stat: got wl=%0d done=%b ferr=%b want %0d %b 0",
                  words_loaded, load_done, frame_err, mcount, mdone);
      end
   endtask

   task automatic test_idle;
      do_reset();
      idle(3 * TO);
      checks++;
      if (frame_err !== 1'b0 || got_addr.size() !== 0) begin
         errs++;
         $display("FAIL idle: got ferr=%b writes=%0d want 0 0",
                  frame_err, got_addr.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_full_image();
      test_random_stream();
      test_idle();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Sits between the UART byte receiver and the instruction memory inside `top`.
- Takes received bytes, packs them little-endian into 32-bit instruction words, and writes each word to consecutive instruction-memory word addresses.
- Asserts `load_done` after the programmed number of words, which releases the core from hold.
- Discards a partial word when the serial stream stalls mid-word, and flags the error.

Parameters:
- NUM_WORDS, 64, number of 32-bit words in a complete program image (256 bytes).
- ADDR_W, 6, instruction-memory word-address width; must satisfy 2**ADDR_W >= NUM_WORDS.
- TIMEOUT_CYCLES, 500_000, clk cycles allowed between bytes of one word before the partial word is dropped (about 5 byte times at 9600 baud, 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  synchronous reset, active-high: asserted while high, sampled on rising clk; driven from sw[15].
- rx_data  input  8  received byte, valid only when rx_valid=1.
- rx_valid  input  1  single-cycle strobe from the UART receiver, one per byte.
- imem_we  output  1  instruction-memory write enable, one-cycle pulse.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  assembled instruction word.
- words_loaded  output  ADDR_W+1  count of words written so far.
- load_done  output  1  sticky; the image is complete.
- frame_err  output  1  sticky; at least one partial word was discarded by timeout.

Behaviour:
- Reset values (rst_n=1 at a clk edge): all of the following are cleared.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - words_loaded=0, load_done=0, frame_err=0.
  - Lane counter=0, timeout counter=0, FSM in COLLECT.
- Reset mid-load: the load restarts from word 0 and any partial word is lost.
- Byte packing:
  - Lane counter 0..3; byte on lane k is stored into word bits [8k+7:8k].
  - Example: bytes 93,02,A0,00 produce 0x00A00293.
- FSM states: COLLECT, WRITE, DONE.
- COLLECT:
  - On rx_valid, store the byte in the current lane and increment the lane counter.
  - On the 4th byte (lane 3), go to WRITE.
- WRITE (exactly one cycle):
  - Drive imem_we=1, imem_addr=word index, imem_wdata=assembled word.
  - imem_we therefore rises in the cycle after the rx_valid that carried byte 3; latency is 1 cycle.
  - On the next edge: word index and words_loaded increment and lane=0.
  - If words_loaded becomes NUM_WORDS, go to DONE; otherwise go to COLLECT.
- imem_addr and imem_wdata hold their last values when imem_we=0; the memory must ignore them.
- Simultaneous events: rx_valid arriving during WRITE is not lost.
  - The byte is stored in lane 0 of the next word, and the lane counter becomes 1 on entry to COLLECT.
  - If WRITE exits to DONE, that byte is ignored.
- Timeout:
  - In COLLECT with lane != 0, the timeout counter increments each cycle without rx_valid and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES-1: the lane counter and partial word clear, frame_err is set, and the word index is unchanged.
  - The counter is held at 0 while lane=0; an idle line before the first byte is never an error.
- DONE:
  - load_done=1 from the first cycle in DONE until reset; imem_we stays 0.
  - All further rx_valid are ignored and words_loaded stays at NUM_WORDS.
- Wrap-around: the word index never exceeds NUM_WORDS-1, because DONE is entered before any wrap.
- Widths:
  - words_loaded is ADDR_W+1 bits, so it holds NUM_WORDS without overflow.
  - The timeout counter is $clog2(TIMEOUT_CYCLES)+1 bits.

Decomposition:
- Shared package `loader_pkg`:
  - enum `loader_state_t` {COLLECT, WRITE, DONE}.
  - Constant `BYTES_PER_WORD`=4.
  - Localparam for the default baud-derived timeout.
- One sub-module, `byte_packer`:
  - Contains the lane counter and the 32-bit shift/insert register, with clear and load controls.
  - The FSM and timeout stay in `imem_uart_loader`.

Test Plan:
- Single word: send 93,02,A0,00 → exactly one imem_we pulse, in the cycle after the 4th rx_valid, with addr=0, wdata=0x00A00293; words_loaded=1.
- Full image:
  - Stimulus: the 64-word program (00A00293, 00528333, 0A5032A3, 005033 83, FE000EE3, then 00000013 fill).
  - Required: 64 writes with addresses 0..63 in order and matching data.
  - load_done rises the cycle after the 64th write.
  - 4 extra bytes afterwards produce no imem_we.
- Timeout (TIMEOUT_CYCLES=16 override):
  - Send 13,00 and then idle 20 cycles → frame_err=1, no write.
  - Then send 33,03,53,00 → write addr=0, wdata=0x00530333.
- Back-to-back: assert rx_valid with byte 0xAA in the WRITE cycle of word 0 → the next word's lane 0 = 0xAA; after 3 more bytes BB,CC,DD, addr=1 and wdata=0xDDCCBBAA.
- Reset mid-load: raise rst_n for 1 cycle after 10 words plus 2 bytes → all outputs are 0; the next 4 bytes write to addr=0.
- Idle: no rx_valid for 3×TIMEOUT_CYCLES after reset → frame_err stays 0 and imem_we stays 0.
